// File: rtl/operand_bypass_ctrl.sv
// rtl/operand_bypass_ctrl.sv - ID/EX operand bypass mux with load-use stall and flush control
module operand_bypass_ctrl #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             B_JUMP,
   input  logic [4:0]       rs1_now,
   input  logic [4:0]       rs2_now,
   input  logic [5:0]       forward_EN1,
   input  logic [5:0]       forward_EN2,
   input  logic             stall_EN1,
   input  logic             stall_EN2,
   input  logic [XLEN-1:0]  rf_rdata1,
   input  logic [XLEN-1:0]  rf_rdata2,
   input  logic [XLEN-1:0]  ex_imm,
   input  logic [XLEN-1:0]  ex_aluout,
   input  logic [XLEN-1:0]  mem_imm,
   input  logic [XLEN-1:0]  mem_aluout,
   input  logic [XLEN-1:0]  mem_rdata,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic [XLEN-1:0]  ex_op1,
   output logic [XLEN-1:0]  ex_op2,
   output logic             ex_valid,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, LDSTALL, FLUSH} state_t;

   state_t          state;
   logic            hz1;
   logic            hz2;
   logic            in_ld;
   logic            do_stall;
   logic [XLEN-1:0] sel1;
   logic [XLEN-1:0] sel2;

   // Operand source for one slot. In the replay cycle the load has reached MEM,
   // so both a latched hazard and a load-use select take the load data; outside
   // it a load-use select only occurs on a bubble cycle, so rf data is harmless.
   function automatic logic [XLEN-1:0] pick(
      input logic [4:0]      rs,
      input logic [5:0]      fwd,
      input logic [XLEN-1:0] rf,
      input logic            hz
   );
      if (rs == 5'd0)    return '0;
      else if (hz)       return mem_rdata;
      else if (fwd[5])   return ex_imm;
      else if (fwd[4])   return mem_imm;
      else if (fwd[3])   return ex_aluout;
      else if (fwd[2])   return mem_aluout;
      else if (fwd[1])   return in_ld ? mem_rdata : rf;
      else if (fwd[0])   return mem_rdata;
      else               return rf;
   endfunction

   // Stall decode and operand selection; stalls only start from RUN and a jump beats them.
   always_comb begin
      in_ld      = (state == LDSTALL);
      do_stall   = (state == RUN) && !B_JUMP && (stall_EN1 || stall_EN2);
      sel1       = pick(rs1_now, forward_EN1, rf_rdata1, hz1 && in_ld);
      sel2       = pick(rs2_now, forward_EN2, rf_rdata2, hz2 && in_ld);
      pc_en      = !rst_n || !do_stall;
      ifid_en    = !rst_n || !do_stall;
      ifid_flush = rst_n && B_JUMP;
   end

   // FSM, ID/EX operand register and saturating event counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         hz1       <= 1'b0;
         hz2       <= 1'b0;
         ex_op1    <= '0;
         ex_op2    <= '0;
         ex_valid  <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (B_JUMP) begin
         state    <= FLUSH;
         hz1      <= 1'b0;
         hz2      <= 1'b0;
         ex_op1   <= '0;
         ex_op2   <= '0;
         ex_valid <= 1'b0;
         if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end else if (do_stall) begin
         state    <= LDSTALL;
         hz1      <= stall_EN1;
         hz2      <= stall_EN2;
         ex_op1   <= '0;
         ex_op2   <= '0;
         ex_valid <= 1'b0;
         if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      end else begin
         state    <= RUN;
         hz1      <= 1'b0;
         hz2      <= 1'b0;
         ex_op1   <= sel1;
         ex_op2   <= sel2;
         ex_valid <= 1'b1;
      end
   end

endmodule
